ram_bus_bridge: RTL and testbench
=================================

Name: ram_bus_bridge

Overview:
Sits directly downstream of the core's RAM port. It converts the core's single-cycle RAM interface (ram_en / ram_write_en / ram_addr / ram_write_data / ram_read_data) into a valid/ready request plus response-valid external bus that may insert wait states. While an access is outstanding it drives the core's stall input high, then returns read data in the single cycle it releases the stall. It also carries a response timeout with a sticky error flag.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waited in RESP before forced completion (1..65535).
ERR_DATA, 32'hDEADBEEF, read data returned on timeout.

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  synchronous, active-high reset
ram_en  in  1  core requests a data access this cycle
ram_write_en  in  4  byte strobes; 0 = read, nonzero = write
ram_addr  in  32  core byte address
ram_write_data  in  32  core store data
ram_read_data  out  32  load data to core, valid in DONE only
core_stall  out  1  wired to core stall; freezes the whole pipeline
bus_req_valid  out  1  request valid
bus_req_ready  in  1  slave accepts request
bus_req_write  out  1  1 = write
bus_req_strb  out  4  byte strobes (4'hF for reads)
bus_req_addr  out  32  word address {addr[31:2],2'b00}
bus_req_wdata  out  32  store data
bus_resp_valid  in  1  response/ack for reads and writes
bus_resp_rdata  in  32  read data
bus_error  out  1  sticky timeout flag

Behaviour:
- Reset (rst=1 at edge): state=IDLE; all registered outputs 0; timeout counter 0; bus_error 0. Reset mid-access abandons it: bus_req_valid is 0 the next cycle, and a late bus_resp_valid in IDLE is ignored.
- core_stall is combinational: 1 when (IDLE and ram_en) or state is REQ or RESP; otherwise 0.
- IDLE: if ram_en, latch the request into registers (write=|ram_write_en, strb = write ? ram_write_en : 4'hF, word addr, wdata), then go to REQ. Otherwise stay.
- REQ: bus_req_valid=1; request fields are held stable from registers. On bus_req_ready=1, go to RESP and clear the counter. Request fields must not change while valid is high and ready is low.
- RESP: bus_req_valid=0. On bus_resp_valid=1, latch bus_resp_rdata (writes latch it too, but the core ignores it) and go to DONE. Otherwise increment the counter. When counter==TIMEOUT_CYCLES-1 with no response, latch ERR_DATA, set bus_error, and go to DONE. A response that coincides with the timeout cycle wins (real data, no error).
- bus_resp_valid is honoured only in RESP. A response in the same cycle as the REQ handshake is illegal for the slave and is ignored.
- DONE: core_stall=0; ram_read_data = latched data. The core advances at this edge. Next state is always IDLE, and ram_en seen in DONE is not reissued.
- ram_read_data outside DONE: holds the last latched value (0 after reset).
- Minimum access: 4 cycles (IDLE-detect, REQ, RESP, DONE) with ready already high and the response one cycle after the handshake. Back-to-back accesses: IDLE re-detects the next ram_en on the cycle after DONE.
- bus_error is cleared only by rst.
- Core-side inputs are sampled only in IDLE; changes during REQ/RESP are ignored.

Decomposition:
- Shared package (bus_pkg alongside bus.v macros): state enum {IDLE, REQ, RESP, DONE} as 2-bit encoding 0..3; RAM_STRB_ALL=4'hF; bus request field widths.
- One natural sub-module: bus_timeout_counter (clear, enable, terminal-count output, width = clog2(TIMEOUT_CYCLES+1)). The FSM and datapath registers stay in ram_bus_bridge.

Test Plan:
- Read, zero wait: ram_en=1, we=0, addr=0x0000_1006, slave ready=1, resp next cycle with 0x1234_5678 -> bus_req_addr=0x0000_1004, strb=F, write=0; core_stall high for 3 cycles; DONE cycle ram_read_data=0x1234_5678, core_stall=0.
- Byte write with backpressure: we=4'b0100, addr=0x20, wdata=0xAABBCCDD, ready low for 5 cycles -> valid held 6 cycles with stable fields; strb=0100, write=1; stall released one cycle after resp.
- Timeout: TIMEOUT_CYCLES=8, no resp -> exactly 8 RESP cycles, DONE with ram_read_data=0xDEADBEEF, bus_error=1 and stays 1 through later good accesses until rst.
- Resp on terminal cycle: resp_valid asserted on 8th RESP cycle with 0x55 -> ram_read_data=0x55, bus_error stays 0.
- Back-to-back: two loads with ram_en held across DONE -> exactly two bus requests, no duplicate issue, second request valid 2 cycles after first DONE.
- Reset mid-RESP: rst=1 during RESP, then stray resp_valid in IDLE -> bus_req_valid=0, core_stall=0 (ram_en=0), ram_read_data=0, no state change.

Source files
------------

// File: rtl/ram_bus_bridge_pkg.sv
// Shared definitions for the core-RAM to valid/ready bus bridge:
// field widths, FSM state codes and the request record.
package ram_bus_bridge_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;

   localparam logic [STRB_W-1:0] RAM_STRB_ALL = 4'hF;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef struct packed {
      logic              write;
      logic [STRB_W-1:0] strb;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } bus_req_t;

   // The bus is word addressed; byte lanes are selected by the strobes.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] byte_addr);
      return {byte_addr[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ram_bus_bridge_if.sv
// External request/response bus: valid/ready request channel plus a
// single-cycle response strobe that may arrive after any number of wait states.
interface ram_bus_bridge_if;
   import ram_bus_bridge_pkg::*;

   logic              bus_req_valid;
   logic              bus_req_ready;
   logic              bus_req_write;
   logic [STRB_W-1:0] bus_req_strb;
   logic [ADDR_W-1:0] bus_req_addr;
   logic [DATA_W-1:0] bus_req_wdata;
   logic              bus_resp_valid;
   logic [DATA_W-1:0] bus_resp_rdata;

   modport master (
      output bus_req_valid, bus_req_write, bus_req_strb, bus_req_addr, bus_req_wdata,
      input  bus_req_ready, bus_resp_valid, bus_resp_rdata
   );

   modport slave (
      input  bus_req_valid, bus_req_write, bus_req_strb, bus_req_addr, bus_req_wdata,
      output bus_req_ready, bus_resp_valid, bus_resp_rdata
   );

endinterface

// File: rtl/ram_bus_bridge_timeout_counter.sv
// Response-wait counter; tc flags the last cycle the bridge is willing to wait.
module ram_bus_bridge_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TC_VALUE = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign tc = (count_reg == TC_VALUE);

endmodule

// File: rtl/ram_bus_bridge.sv
// Turns the core's single-cycle RAM port into a wait-state tolerant bus
// access, stalling the core until the response (or a timeout) completes it.
module ram_bus_bridge
   import ram_bus_bridge_pkg::*;
#(
   parameter int                TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0] ERR_DATA       = 32'hDEADBEEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ram_en,
   input  logic [STRB_W-1:0] ram_write_en,
   input  logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_write_data,
   output logic [DATA_W-1:0] ram_read_data,
   output logic              core_stall,
   ram_bus_bridge_if.master  bus,
   output logic              bus_error
);

   logic [1:0]        state_reg;
   logic [1:0]        state_next;
   bus_req_t          req_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic              error_reg;

   logic handshake;
   logic resp_hit;
   logic timeout_tc;
   logic timeout_en;
   logic timeout_fire;

   assign handshake    = (state_reg == ST_REQ) && bus.bus_req_ready;
   assign resp_hit     = (state_reg == ST_RESP) && bus.bus_resp_valid;
   assign timeout_en   = (state_reg == ST_RESP) && !bus.bus_resp_valid && !timeout_tc;
   // A response landing on the terminal cycle takes priority over the timeout.
   assign timeout_fire = (state_reg == ST_RESP) && !bus.bus_resp_valid && timeout_tc;

   ram_bus_bridge_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (handshake),
      .enable (timeout_en),
      .tc     (timeout_tc)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (ram_en) state_next = ST_REQ;
         ST_REQ:  if (bus.bus_req_ready) state_next = ST_RESP;
         ST_RESP: if (resp_hit || timeout_fire) state_next = ST_DONE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Core inputs are captured only in IDLE so the core may change them freely while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_reg   <= '0;
         rdata_reg <= '0;
         error_reg <= 1'b0;
      end else begin
         if ((state_reg == ST_IDLE) && ram_en) begin
            req_reg.write <= |ram_write_en;
            req_reg.strb  <= (|ram_write_en) ? ram_write_en : RAM_STRB_ALL;
            req_reg.addr  <= word_addr(ram_addr);
            req_reg.wdata <= ram_write_data;
         end
         if (resp_hit) begin
            rdata_reg <= bus.bus_resp_rdata;
         end else if (timeout_fire) begin
            rdata_reg <= ERR_DATA;
            error_reg <= 1'b1;
         end
      end
   end

   assign core_stall = ((state_reg == ST_IDLE) && ram_en) ||
                       (state_reg == ST_REQ) || (state_reg == ST_RESP);

   assign bus.bus_req_valid = (state_reg == ST_REQ);
   assign bus.bus_req_write = req_reg.write;
   assign bus.bus_req_strb  = req_reg.strb;
   assign bus.bus_req_addr  = req_reg.addr;
   assign bus.bus_req_wdata = req_reg.wdata;

   assign ram_read_data = rdata_reg;
   assign bus_error     = error_reg;

endmodule

// File: tb/tb_ram_bus_bridge.sv
// Randomized scoreboard bench for ram_bus_bridge with a transaction-level
// model of request fields, stall length, returned data and the sticky error.
module tb_ram_bus_bridge;
   import ram_bus_bridge_pkg::*;

   localparam int          TMO = 8;
   localparam logic [31:0] ERR = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ram_en = 1'b0;
   logic [3:0]  ram_write_en = 4'h0;
   logic [31:0] ram_addr = 32'h0;
   logic [31:0] ram_write_data = 32'h0;
   logic [31:0] ram_read_data;
   logic        core_stall;
   logic        bus_error;

   ram_bus_bridge_if bus_if ();

   ram_bus_bridge #(
      .TIMEOUT_CYCLES (TMO),
      .ERR_DATA       (ERR)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ram_en         (ram_en),
      .ram_write_en   (ram_write_en),
      .ram_addr       (ram_addr),
      .ram_write_data (ram_write_data),
      .ram_read_data  (ram_read_data),
      .core_stall     (core_stall),
      .bus            (bus_if),
      .bus_error      (bus_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        write;
      logic [3:0]  strb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_exp_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          stall_cycles;
   } rsp_exp_t;

   req_exp_t req_q[$];
   rsp_exp_t rsp_q[$];
   int       checks = 0;
   int       errors = 0;
   bit       err_model = 1'b0;
   int       txn_num = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every valid request cycle against the head of the
   // request queue, and each stall release against the head of the response queue.
   initial begin : monitor
      int       stall_cnt;
      rsp_exp_t e;
      stall_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_cnt = 0;
         end else begin
            if (bus_if.bus_req_valid) begin
               if (req_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_req: got valid=1 addr=0x%08h expected no request", bus_if.bus_req_addr);
               end else begin
                  check32("req_write", {31'b0, bus_if.bus_req_write}, {31'b0, req_q[0].write});
                  check32("req_strb", {28'b0, bus_if.bus_req_strb}, {28'b0, req_q[0].strb});
                  check32("req_addr", bus_if.bus_req_addr, req_q[0].addr);
                  check32("req_wdata", bus_if.bus_req_wdata, req_q[0].wdata);
                  if (bus_if.bus_req_ready) void'(req_q.pop_front());
               end
            end
            if (core_stall) begin
               stall_cnt++;
            end else if (stall_cnt > 0) begin
               if (rsp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: got stall release expected none");
               end else begin
                  e = rsp_q.pop_front();
                  check32("rdata", ram_read_data, e.rdata);
                  check32("bus_error", {31'b0, bus_error}, {31'b0, e.err});
                  check32("stall_cycles", 32'(stall_cnt), 32'(e.stall_cycles));
                  $display("txn %0d: rdata=0x%08h bus_error=%0b stall_cycles=%0d", txn_num, ram_read_data, bus_error, stall_cnt);
                  txn_num++;
               end
               stall_cnt = 0;
            end
         end
      end
   end

   // Drives one core access and plays the slave. Starts and ends in an IDLE cycle.
   task automatic access(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int rdy_wait, input int resp_wait, input logic [31:0] rdata,
                         input bit hold_en, input bit bad_resp);
      req_exp_t r;
      rsp_exp_t s;
      bit       tmo;
      r.write = |we;
      r.strb  = r.write ? we : 4'hF;
      r.addr  = addr & 32'hFFFF_FFFC;
      r.wdata = wdata;
      tmo = (resp_wait >= TMO);
      if (tmo) err_model = 1'b1;
      s.rdata        = tmo ? ERR : rdata;
      s.err          = err_model;
      s.stall_cycles = 1 + (rdy_wait + 1) + (tmo ? TMO : resp_wait + 1);
      req_q.push_back(r);
      rsp_q.push_back(s);

      ram_en         = 1'b1;
      ram_write_en   = we;
      ram_addr       = addr;
      ram_write_data = wdata;
      bus_if.bus_req_ready = (rdy_wait == 0);
      next_cycle();
      ram_write_en   = 4'($urandom);
      ram_addr       = $urandom;
      ram_write_data = $urandom;
      for (int i = 0; i < rdy_wait; i++) begin
         bus_if.bus_req_ready = 1'b0;
         next_cycle();
      end
      bus_if.bus_req_ready = 1'b1;
      if (bad_resp) begin
         bus_if.bus_resp_valid = 1'b1;
         bus_if.bus_resp_rdata = $urandom;
      end
      next_cycle();
      bus_if.bus_req_ready  = 1'b0;
      bus_if.bus_resp_valid = 1'b0;
      for (int i = 0; i < (tmo ? TMO : resp_wait); i++) next_cycle();
      if (!tmo) begin
         bus_if.bus_resp_valid = 1'b1;
         bus_if.bus_resp_rdata = rdata;
         next_cycle();
         bus_if.bus_resp_valid = 1'b0;
      end
      ram_en = hold_en;
      next_cycle();
      ram_en = 1'b0;
   endtask

   task automatic reset_mid_resp();
      req_exp_t r;
      r.write = 1'b0;
      r.strb  = 4'hF;
      r.addr  = 32'h0000_0440;
      r.wdata = 32'h0;
      req_q.push_back(r);
      ram_en = 1'b1;
      ram_write_en = 4'h0;
      ram_addr = 32'h0000_0443;
      ram_write_data = 32'h0;
      bus_if.bus_req_ready = 1'b1;
      next_cycle();
      next_cycle();
      bus_if.bus_req_ready = 1'b0;
      next_cycle();
      rst = 1'b1;
      ram_en = 1'b0;
      next_cycle();
      rst = 1'b0;
      err_model = 1'b0;
      bus_if.bus_resp_valid = 1'b1;
      bus_if.bus_resp_rdata = 32'h0000_0099;
      @(negedge clk);
      check32("rstmid_valid", {31'b0, bus_if.bus_req_valid}, 32'h0);
      check32("rstmid_stall", {31'b0, core_stall}, 32'h0);
      check32("rstmid_rdata", ram_read_data, 32'h0);
      check32("rstmid_error", {31'b0, bus_error}, 32'h0);
      next_cycle();
      bus_if.bus_resp_valid = 1'b0;
      @(negedge clk);
      check32("rstmid_stray_rdata", ram_read_data, 32'h0);
      check32("rstmid_stray_stall", {31'b0, core_stall}, 32'h0);
      check32("rstmid_stray_valid", {31'b0, bus_if.bus_req_valid}, 32'h0);
      next_cycle();
   endtask

   initial begin : stimulus
      logic [3:0] we;
      bus_if.bus_req_ready  = 1'b0;
      bus_if.bus_resp_valid = 1'b0;
      bus_if.bus_resp_rdata = 32'h0;
      rst = 1'b1;
      repeat (3) next_cycle();
      @(negedge clk);
      check32("rst_valid", {31'b0, bus_if.bus_req_valid}, 32'h0);
      check32("rst_stall", {31'b0, core_stall}, 32'h0);
      check32("rst_rdata", ram_read_data, 32'h0);
      check32("rst_error", {31'b0, bus_error}, 32'h0);
      check32("rst_addr", bus_if.bus_req_addr, 32'h0);
      check32("rst_strb", {28'b0, bus_if.bus_req_strb}, 32'h0);
      next_cycle();
      rst = 1'b0;
      next_cycle();

      access(4'h0, 32'h0000_1006, 32'h0, 0, 0, 32'h1234_5678, 1'b0, 1'b0);
      access(4'b0100, 32'h0000_0020, 32'hAABB_CCDD, 5, 0, 32'h0BAD_F00D, 1'b0, 1'b0);
      access(4'h0, 32'h0000_0100, 32'h0, 0, 7, 32'h0000_0055, 1'b0, 1'b0);
      access(4'h0, 32'h0000_0200, 32'h0, 1, 8, 32'h1111_1111, 1'b0, 1'b0);
      access(4'hF, 32'h0000_0304, 32'hCAFE_0001, 0, 2, 32'h2222_2222, 1'b0, 1'b1);
      access(4'h0, 32'h0000_0400, 32'h0, 0, 0, 32'h3333_3333, 1'b1, 1'b0);
      access(4'h0, 32'h0000_0404, 32'h0, 0, 0, 32'h4444_4444, 1'b0, 1'b0);
      reset_mid_resp();
      access(4'h0, 32'h0000_0500, 32'h0, 0, 1, 32'h5555_AAAA, 1'b0, 1'b0);

      for (int n = 0; n < 30; n++) begin
         we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
         access(we, $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
                $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      repeat (3) next_cycle();
      check32("req_q_empty", 32'(req_q.size()), 32'h0);
      check32("rsp_q_empty", 32'(rsp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
